// File: rtl/interboard_receiver_pkg.sv
// ==========================================================================
// interboard_receiver_pkg : shared link constants, message codes, FSM states
// Rev 1.0
// ==========================================================================
`default_nettype none

package interboard_receiver_pkg;

  localparam logic [3:0] MSG_RST      = 4'd1;
  localparam logic [3:0] MSG_MOVE     = 4'd2;
  localparam logic [3:0] MSG_DRAW     = 4'd3;
  localparam logic [3:0] MSG_END_TURN = 4'd4;

  localparam int IB_DATA_W = 6;
  localparam int IB_WORDS  = 3;

  typedef enum logic [1:0] {
    ST_DRAIN    = 2'd0,
    ST_WAIT_REQ = 2'd1,
    ST_ACKED    = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/interboard_receiver_sync_2ff.sv
// ==========================================================================
// sync_2ff : single-bit two-flop synchronizer, synchronous active-high reset
// Rev 1.0
// ==========================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/interboard_receiver.sv
// ==========================================================================
// interboard_receiver : 4-phase req/ack receiver for 3-word inter-board packets
// Rev 1.0
// ==========================================================================
`default_nettype none

module interboard_receiver
  import interboard_receiver_pkg::*;
#(
  parameter int PLAYER  = 0,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_in,
  input  logic [IB_DATA_W-1:0] data_in,
  output logic                 ack_out,
  output logic                 msg_valid,
  output logic [3:0]           msg_type,
  output logic                 msg_player,
  output logic [11:0]          msg_payload,
  output logic                 interboard_rst,
  output logic                 link_err
);

  localparam int              CW         = (TIMEOUT > 4) ? $clog2(TIMEOUT) : 2;
  localparam logic [CW-1:0]   c_TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   c_SETTLE   = CW'(2);
  localparam logic [1:0]      c_LAST_IDX = 2'(IB_WORDS - 1);
  localparam logic            c_PLAYER   = 1'(PLAYER);

  logic w_req_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (req_in),
    .o_q (w_req_s)
  );

  rx_state_t               r_state, w_state_nx;
  logic [1:0]              r_word_idx, w_idx_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx;
  logic [IB_DATA_W-1:1]    r_w0, w_w0_nx;
  logic [IB_DATA_W-1:0]    r_w1, w_w1_nx, r_w2, w_w2_nx;
  logic                    r_ack, w_ack_nx;
  logic                    r_valid, w_valid_nx;
  logic                    r_irst, w_irst_nx;
  logic                    r_err, w_err_nx;
  logic [3:0]              r_type, w_type_nx;
  logic                    r_pl, w_pl_nx;
  logic [11:0]             r_pay, w_pay_nx;
  logic                    w_timeout;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_word_idx;
    w_cnt_nx   = r_cnt;
    w_w0_nx    = r_w0;
    w_w1_nx    = r_w1;
    w_w2_nx    = r_w2;
    w_ack_nx   = r_ack;
    w_valid_nx = 1'b0;
    w_irst_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_type_nx  = r_type;
    w_pl_nx    = r_pl;
    w_pay_nx   = r_pay;
    w_timeout  = (r_cnt == c_TO_LAST);

    case (r_state)
      // Wait for the synchronizer to flush before trusting a low req_s, so a
      // req that was already high across reset is never taken as a fresh rise.
      ST_DRAIN: begin
        w_ack_nx = 1'b0;
        if (!w_req_s && r_cnt >= c_SETTLE) begin
          w_state_nx = ST_WAIT_REQ;
        end else if (r_cnt < c_SETTLE) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end

      ST_WAIT_REQ: begin
        if (w_req_s) begin
          case (r_word_idx)
            2'd0:    w_w0_nx = data_in[IB_DATA_W-1:1];
            2'd1:    w_w1_nx = data_in;
            default: w_w2_nx = data_in;
          endcase
          w_ack_nx   = 1'b1;
          w_state_nx = ST_ACKED;
        end else if (r_word_idx != 2'd0) begin
          if (w_timeout) begin
            w_err_nx   = 1'b1;
            w_ack_nx   = 1'b0;
            w_idx_nx   = 2'd0;
            w_state_nx = ST_DRAIN;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end

      ST_ACKED: begin
        if (!w_req_s) begin
          w_ack_nx   = 1'b0;
          w_state_nx = ST_WAIT_REQ;
          if (r_word_idx < c_LAST_IDX) begin
            w_idx_nx = r_word_idx + 2'd1;
          end else begin
            w_idx_nx = 2'd0;
            if (r_w0[1] != c_PLAYER) begin
              w_valid_nx = 1'b1;
              w_type_nx  = r_w0[5:2];
              w_pl_nx    = r_w0[1];
              w_pay_nx   = {r_w1, r_w2};
              w_irst_nx  = (r_w0[5:2] == MSG_RST);
            end else begin
              w_err_nx = 1'b1;
            end
          end
        end else if (w_timeout) begin
          w_err_nx   = 1'b1;
          w_ack_nx   = 1'b0;
          w_idx_nx   = 2'd0;
          w_state_nx = ST_DRAIN;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end

      default: w_state_nx = ST_DRAIN;
    endcase

    if (w_state_nx != r_state) begin
      w_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_DRAIN;
      r_word_idx <= 2'd0;
      r_cnt      <= '0;
      r_w0       <= '0;
      r_w1       <= '0;
      r_w2       <= '0;
      r_ack      <= 1'b0;
      r_valid    <= 1'b0;
      r_irst     <= 1'b0;
      r_err      <= 1'b0;
      r_type     <= 4'd0;
      r_pl       <= 1'b0;
      r_pay      <= 12'd0;
    end else begin
      r_state    <= w_state_nx;
      r_word_idx <= w_idx_nx;
      r_cnt      <= w_cnt_nx;
      r_w0       <= w_w0_nx;
      r_w1       <= w_w1_nx;
      r_w2       <= w_w2_nx;
      r_ack      <= w_ack_nx;
      r_valid    <= w_valid_nx;
      r_irst     <= w_irst_nx;
      r_err      <= w_err_nx;
      r_type     <= w_type_nx;
      r_pl       <= w_pl_nx;
      r_pay      <= w_pay_nx;
    end
  end

  assign ack_out        = r_ack;
  assign msg_valid      = r_valid;
  assign msg_type       = r_type;
  assign msg_player     = r_pl;
  assign msg_payload    = r_pay;
  assign interboard_rst = r_irst;
  assign link_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_interboard_receiver.sv
// ==========================================================================
// tb_interboard_receiver : transaction-level model bench for interboard_receiver
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_interboard_receiver;

  localparam int PL = 0;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_in = 1'b0;
  logic [5:0]  data_in = 6'd0;
  logic        ack_out, msg_valid, msg_player, interboard_rst, link_err;
  logic [3:0]  msg_type;
  logic [11:0] msg_payload;

  interboard_receiver #(.PLAYER(PL), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_in         (req_in),
    .data_in        (data_in),
    .ack_out        (ack_out),
    .msg_valid      (msg_valid),
    .msg_type       (msg_type),
    .msg_player     (msg_player),
    .msg_payload    (msg_payload),
    .interboard_rst (interboard_rst),
    .link_err       (link_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // kind: 0 = delivered message, 1 = own-ID reject, 2 = timeout
  typedef struct {
    int         kind;
    logic [3:0] typ;
    logic       pl;
    logic [11:0] pay;
  } ev_t;

  ev_t         exp_q[$];
  logic [3:0]  h_type = 4'd0;
  logic        h_pl   = 1'b0;
  logic [11:0] h_pay  = 12'd0;
  int n_cmp = 0, n_fail = 0;
  int n_valid_seen = 0, n_rst_seen = 0, n_err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic ev_t model_pkt(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    ev_t e;
    int ai, bi, ci;
    ai = a; bi = b; ci = c;
    e.typ  = 4'(ai / 4);
    e.pl   = 1'((ai / 2) % 2);
    e.pay  = 12'(bi * 64 + ci);
    e.kind = (int'(e.pl) == PL) ? 1 : 0;
    return e;
  endfunction

  // Per-cycle compare against the transaction model
  initial begin
    logic prev_ack;
    ev_t  e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ack = 1'b0;
      end else begin
        if (msg_valid) n_valid_seen++;
        if (interboard_rst) n_rst_seen++;
        if (link_err) n_err_seen++;
        if (msg_valid || link_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, msg_valid, link_err}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.kind == 0) begin
              chk("valid_pulse", {msg_valid, link_err}, 2'b10);
              chk("msg_type", msg_type, e.typ);
              chk("msg_player", msg_player, e.pl);
              chk("msg_payload", msg_payload, e.pay);
              chk("interboard_rst", interboard_rst, (e.typ == 4'd1));
              chk("valid_on_ack_fall", {prev_ack, ack_out}, 2'b10);
              h_type = e.typ; h_pl = e.pl; h_pay = e.pay;
            end else begin
              chk("err_pulse", {msg_valid, link_err, interboard_rst}, 3'b010);
              chk("err_hold_type", msg_type, h_type);
              chk("err_hold_player", msg_player, h_pl);
              chk("err_hold_payload", msg_payload, h_pay);
              if (e.kind == 1) chk("err_on_ack_fall", {prev_ack, ack_out}, 2'b10);
            end
          end
        end else begin
          chk("idle_irst", interboard_rst, 1'b0);
          chk("hold_fields", {msg_type, msg_player, msg_payload}, {h_type, h_pl, h_pay});
        end
        prev_ack = ack_out;
      end
    end
  end

  task automatic wait_ack(input logic v, output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack_out === v) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_wait: ack_out %0b required, never seen", v);
    end
  endtask

  task automatic send_word(input logic [5:0] d, input int hold);
    int t0, t1;
    @(posedge clk); #1;
    data_in = d; req_in = 1'b1; t0 = cyc;
    wait_ack(1'b1, t1);
    if (t1 >= 0) chk("ack_rise_latency", t1 - t0, 3);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    req_in = 1'b0; t0 = cyc;
    data_in = 6'($urandom);
    wait_ack(1'b0, t1);
    if (t1 >= 0) chk("ack_fall_latency", t1 - t0, 3);
  endtask

  task automatic send_pkt(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input int hold);
    exp_q.push_back(model_pkt(a, b, c));
    send_word(a, hold);
    send_word(b, hold);
    send_word(c, hold);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    h_type = 4'd0; h_pl = 1'b0; h_pay = 12'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ack_immediate", ack_out, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t m;
    int  v0, e0, tA, seen;
    logic [5:0] a, b, c;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {ack_out, msg_valid, interboard_rst, link_err, msg_type, msg_player, msg_payload}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // Pin the model with hand-computed values
    m = model_pkt(6'h06, 6'h2A, 6'h15);
    chk("model_type", m.typ, 4'd1);
    chk("model_player", m.pl, 1'b1);
    chk("model_payload", m.pay, 12'hA95);
    chk("model_kind", m.kind, 0);
    m = model_pkt(6'h08, 6'h01, 6'h02);
    chk("model_own_kind", m.kind, 1);
    chk("model_own_type", m.typ, 4'd2);

    // Reset-type packet from the peer
    send_pkt(6'h06, 6'h2A, 6'h15, 1);
    @(negedge clk);
    chk("lit_payload", msg_payload, 12'hA95);
    chk("lit_type", msg_type, 4'd1);
    chk("lit_valid_count", n_valid_seen, 1);
    chk("lit_rst_count", n_rst_seen, 1);

    // Own-ID packet rejected
    send_pkt(6'h08, 6'h11, 6'h22, 0);
    @(negedge clk);
    chk("own_err_count", n_err_seen, 1);
    chk("own_no_valid", n_valid_seen, 1);
    chk("own_payload_held", msg_payload, 12'hA95);

    // Timeout after word1, then a clean packet
    m.kind = 2; m.typ = 4'd0; m.pl = 1'b0; m.pay = 12'd0;
    exp_q.push_back(m);
    send_word(6'h0A, 0);
    send_word(6'h33, 0);
    tA = cyc;
    seen = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (link_err) begin
        seen = cyc;
        break;
      end
    end
    chk("timeout_latency", seen - tA, TO);
    repeat (6) @(posedge clk);
    send_pkt(6'h0A, 6'h3F, 6'h00, 2);
    @(negedge clk);
    chk("post_timeout_payload", msg_payload, 12'hFC0);
    chk("post_timeout_type", msg_type, 4'd2);

    // Reset while req is high mid-word
    @(posedge clk); #1;
    data_in = 6'h3E; req_in = 1'b1;
    wait_ack(1'b1, tA);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_capture_while_req_high", {ack_out, msg_valid, link_err}, 3'b000);
    end
    @(posedge clk); #1;
    req_in = 1'b0;
    repeat (8) @(posedge clk);
    send_pkt(6'h12, 6'h05, 6'h2C, 0);
    @(negedge clk);
    chk("post_reset_payload", msg_payload, 12'h16C);

    // Two back-to-back packets with no gap
    v0 = n_valid_seen;
    send_pkt(6'h0E, 6'h01, 6'h02, 0);
    send_pkt(6'h12, 6'h03, 6'h04, 0);
    @(negedge clk);
    chk("b2b_valid_count", n_valid_seen - v0, 2);
    chk("b2b_last_payload", msg_payload, 12'h0C4);

    // Randomized packets
    v0 = n_valid_seen; e0 = n_err_seen;
    for (int k = 0; k < 40; k++) begin
      a = 6'($urandom); b = 6'($urandom); c = 6'($urandom);
      send_pkt(a, b, c, int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("random_pulse_total", (n_valid_seen - v0) + (n_err_seen - e0), 40);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
